// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I main controller.
package mc_ctrl_pkg;

    localparam int unsigned OPC_BITS = 7;
    localparam int unsigned F3_W     = 3;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned CNT_W    = 32;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_MEM_ADDR,
        ST_MEM_READ,
        ST_MEM_WB,
        ST_MEM_WRITE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_JAL,
        ST_ALU_WB,
        ST_BRANCH,
        ST_HALT
    } state_e;

    localparam logic [OPC_BITS-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_BITS-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_BITS-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_BITS-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_BITS-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_BITS-1:0] OPC_JAL    = 7'b1101111;

    localparam logic [F3_W-1:0] F3_BEQ = 3'b000;
    localparam logic [F3_W-1:0] F3_BNE = 3'b001;

    localparam logic [SEL_W-1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] SRC_A_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRC_A_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] SRC_B_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRC_B_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRC_B_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] RES_ALUOUT  = 2'b00;
    localparam logic [SEL_W-1:0] RES_MEMDATA = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALU     = 2'b10;

    // Datapath control bundle driven by the output decode.
    typedef struct packed {
        logic             mem_req;
        logic             mem_we;
        logic             addr_src;
        logic             ir_write;
        logic             pc_write;
        logic             reg_write;
        logic [SEL_W-1:0] alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic [SEL_W-1:0] result_src;
        logic             illegal;
    } ctrl_s;

endpackage

// File: rtl/mc_opcode_class.sv
// DECODE-state dispatch: maps opcode/funct3 to the next state and flags
// unsupported encodings.
module mc_opcode_class
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned OPC_W = 7
) (
    input  logic [OPC_W-1:0] opcode,
    input  logic [F3_W-1:0]  fun3,
    output state_e           dispatch_c,
    output logic             illegal_c
);

    always_comb begin
        dispatch_c = ST_HALT;
        case (opcode)
            OPC_LOAD, OPC_STORE: dispatch_c = ST_MEM_ADDR;
            OPC_OP:              dispatch_c = ST_EXEC_R;
            OPC_OP_IMM:          dispatch_c = ST_EXEC_I;
            OPC_JAL:             dispatch_c = ST_JAL;
            OPC_BRANCH: begin
                if (fun3 == F3_BEQ || fun3 == F3_BNE) begin
                    dispatch_c = ST_BRANCH;
                end
            end
            default: dispatch_c = ST_HALT;
        endcase
        illegal_c = (dispatch_c == ST_HALT);
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle main control FSM for the RV32I core.
// Optional retired-instruction counter enabled by MC_CTRL_INSTRET_EN.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned OPC_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] opcode,
    input  logic [2:0]       fun3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       result_src,
    output logic             illegal
`ifdef MC_CTRL_INSTRET_EN
    ,
    output logic [31:0]      instret
`endif
);

    state_e state_q, state_d;
    state_e dispatch_c;
    logic   dec_illegal_c;
    ctrl_s  ctrl_c;

    mc_opcode_class #(.OPC_W(OPC_W)) u_opcode_class (
        .opcode     (opcode),
        .fun3       (fun3),
        .dispatch_c (dispatch_c),
        .illegal_c  (dec_illegal_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; memory states wait for mem_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      state_d = ST_FETCH;
            ST_FETCH:     if (mem_ready) state_d = ST_DECODE;
            ST_DECODE:    state_d = dec_illegal_c ? ST_HALT : dispatch_c;
            ST_MEM_ADDR:  state_d = (opcode == OPC_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ:  if (mem_ready) state_d = ST_MEM_WB;
            ST_MEM_WB:    state_d = ST_FETCH;
            ST_MEM_WRITE: if (mem_ready) state_d = ST_FETCH;
            ST_EXEC_R:    state_d = ST_ALU_WB;
            ST_EXEC_I:    state_d = ST_ALU_WB;
            ST_JAL:       state_d = ST_ALU_WB;
            ST_ALU_WB:    state_d = ST_FETCH;
            ST_BRANCH:    state_d = ST_FETCH;
            ST_HALT:      state_d = ST_HALT;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Moore output decode; only FETCH and BRANCH strobes look at inputs.
    always_comb begin
        ctrl_c = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl_c.mem_req    = 1'b1;
                ctrl_c.addr_src   = 1'b0;
                ctrl_c.alu_src_a  = SRC_A_PC;
                ctrl_c.alu_src_b  = SRC_B_FOUR;
                ctrl_c.alu_op     = ALU_OP_ADD;
                ctrl_c.result_src = RES_ALU;
                ctrl_c.ir_write   = mem_ready;
                ctrl_c.pc_write   = mem_ready;
            end
            ST_DECODE: begin
                ctrl_c.alu_src_a = SRC_A_OLDPC;
                ctrl_c.alu_src_b = SRC_B_IMM;
                ctrl_c.alu_op    = ALU_OP_ADD;
            end
            ST_MEM_ADDR: begin
                ctrl_c.alu_src_a = SRC_A_RS1;
                ctrl_c.alu_src_b = SRC_B_IMM;
                ctrl_c.alu_op    = ALU_OP_ADD;
            end
            ST_MEM_READ: begin
                ctrl_c.mem_req  = 1'b1;
                ctrl_c.addr_src = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.result_src = RES_MEMDATA;
            end
            ST_MEM_WRITE: begin
                ctrl_c.mem_req  = 1'b1;
                ctrl_c.mem_we   = 1'b1;
                ctrl_c.addr_src = 1'b1;
            end
            ST_EXEC_R: begin
                ctrl_c.alu_src_a = SRC_A_RS1;
                ctrl_c.alu_src_b = SRC_B_RS2;
                ctrl_c.alu_op    = ALU_OP_FUNCT;
            end
            ST_EXEC_I: begin
                ctrl_c.alu_src_a = SRC_A_RS1;
                ctrl_c.alu_src_b = SRC_B_IMM;
                ctrl_c.alu_op    = ALU_OP_FUNCT;
            end
            ST_JAL: begin
                ctrl_c.alu_src_a  = SRC_A_OLDPC;
                ctrl_c.alu_src_b  = SRC_B_FOUR;
                ctrl_c.alu_op     = ALU_OP_ADD;
                ctrl_c.result_src = RES_ALUOUT;
                ctrl_c.pc_write   = 1'b1;
            end
            ST_ALU_WB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.result_src = RES_ALUOUT;
            end
            ST_BRANCH: begin
                ctrl_c.alu_src_a  = SRC_A_RS1;
                ctrl_c.alu_src_b  = SRC_B_RS2;
                ctrl_c.alu_op     = ALU_OP_SUB;
                ctrl_c.result_src = RES_ALUOUT;
                ctrl_c.pc_write   = ((fun3 == F3_BEQ) &&  zero) ||
                                    ((fun3 == F3_BNE) && !zero);
            end
            ST_HALT: ctrl_c.illegal = 1'b1;
            default: ctrl_c = '0;
        endcase
    end

    assign mem_req    = ctrl_c.mem_req;
    assign mem_we     = ctrl_c.mem_we;
    assign addr_src   = ctrl_c.addr_src;
    assign ir_write   = ctrl_c.ir_write;
    assign pc_write   = ctrl_c.pc_write;
    assign reg_write  = ctrl_c.reg_write;
    assign alu_src_a  = ctrl_c.alu_src_a;
    assign alu_src_b  = ctrl_c.alu_src_b;
    assign alu_op     = ctrl_c.alu_op;
    assign result_src = ctrl_c.result_src;
    assign illegal    = ctrl_c.illegal;

`ifdef MC_CTRL_INSTRET_EN
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire_c;

    // An instruction retires when its last state hands back to FETCH.
    always_comb begin
        retire_c  = (state_d == ST_FETCH) &&
                    (state_q inside {ST_MEM_WB, ST_MEM_WRITE, ST_ALU_WB, ST_BRANCH});
        instret_d = retire_c ? instret_q + CNT_W'(1) : instret_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`endif

endmodule
